// File: rtl/pr_pkg.sv
// Shared types for the pr_skid pipeline register: state encoding and occupancy width.
package pr_pkg;

  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,
    PR_BUSY  = 2'd1,
    PR_FULL  = 2'd2
  } pr_state_e;

  localparam int OCC_W = 2;

  // Number of held entries for a given state; unused encodings report empty.
  function automatic logic [OCC_W-1:0] pr_occ(input logic [1:0] st);
    logic [OCC_W-1:0] occ;
    occ = '0;
    if (st == PR_BUSY) occ = 2'd1;
    if (st == PR_FULL) occ = 2'd2;
    return occ;
  endfunction

endpackage

// File: rtl/pr_skid_slot.sv
// One payload register with its valid bit; clear outranks load.
// Data survives a clear unless clear_data is also set.
module pr_skid_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_data,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
      if (clear_data) q <= '0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/pr_skid.sv
// Elastic pipeline register: 1-cycle latency, full throughput; SKID=1 registers o_ready
// via a two-entry skid, SKID=0 passes downstream ready through. Flush beats stall.
module pr_skid
  import pr_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit SKID           = 1'b1,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [OCC_W-1:0]  o_occupancy
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              in_fire;
  logic              out_fire;
  logic              m_load;
  logic              m_clr;
  logic              s_load;
  logic              s_clr;
  logic              clr_data;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] s_q;
  logic              m_vld;
  logic              s_vld;
  logic              unused_vld;

  assign o_valid     = (state_q == PR_BUSY) || (state_q == PR_FULL);
  assign o_occupancy = pr_occ(state_q);

  // Reset gates ready combinationally so nothing is offered while rst_n is low.
  generate
    if (SKID) begin : g_rdy_skid
      assign o_ready = rst_n & ~i_stall & ~i_flush &
                       ((state_q == PR_EMPTY) || (state_q == PR_BUSY));
    end else begin : g_rdy_pass
      assign o_ready = rst_n & ~i_stall & ~i_flush & (~o_valid | i_ready);
    end
  endgenerate

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready & ~i_stall;
  assign clr_data = i_flush & CLEAR_ON_FLUSH;

  always_comb begin
    state_d = state_q;
    m_load  = 1'b0;
    m_clr   = 1'b0;
    s_load  = 1'b0;
    s_clr   = 1'b0;
    m_d     = i_data;
    if (i_flush) begin
      state_d = PR_EMPTY;
      m_clr   = 1'b1;
      s_clr   = 1'b1;
    end else if (!i_stall) begin
      case (state_q)
        PR_EMPTY: begin
          if (in_fire) begin
            state_d = PR_BUSY;
            m_load  = 1'b1;
          end
        end
        PR_BUSY: begin
          if (in_fire && out_fire) begin
            m_load = 1'b1;
          end else if (in_fire && SKID) begin
            state_d = PR_FULL;
            s_load  = 1'b1;
          end else if (out_fire) begin
            state_d = PR_EMPTY;
            m_clr   = 1'b1;
          end
        end
        PR_FULL: begin
          if (!SKID) begin
            state_d = PR_EMPTY;
            m_clr   = 1'b1;
          end else if (out_fire) begin
            // Skid entry is older than anything upstream, so it moves into M.
            state_d = PR_BUSY;
            m_load  = 1'b1;
            m_d     = s_q;
            s_clr   = 1'b1;
          end
        end
        default: begin
          state_d = PR_EMPTY;
          m_clr   = 1'b1;
          s_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PR_EMPTY;
    else        state_q <= state_d;
  end

  pr_skid_slot #(.DATA_W(DATA_W)) u_m (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (m_load),
    .clear      (m_clr),
    .clear_data (clr_data),
    .d          (m_d),
    .q          (o_data),
    .vld        (m_vld)
  );

  generate
    if (SKID) begin : g_skid
      pr_skid_slot #(.DATA_W(DATA_W)) u_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (s_load),
        .clear      (s_clr),
        .clear_data (clr_data),
        .d          (i_data),
        .q          (s_q),
        .vld        (s_vld)
      );
    end else begin : g_noskid
      logic unused_s;
      assign s_q      = '0;
      assign s_vld    = 1'b0;
      assign unused_s = s_load ^ s_clr;
    end
  endgenerate

  // Occupancy comes from the state; the slot valid bits are informational only.
  assign unused_vld = m_vld ^ s_vld;

endmodule
